// File: rtl/dffrf_bist.sv
// March-style self-test controller for the 2R1W flop register file: W0 writes
// address-keyed patterns, R0W1 reads/inverts them, R1 reads back descending.
module dffrf_bist #(
   parameter int data_w    = 32,
   parameter int addr_w    = 5,
   parameter int USE_LATCH = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [addr_w-1:0] FAIL_ADDR,
   output logic [1:0]        FAIL_PORT,
   output logic              FAIL_PHASE,
   output logic [7:0]        ERR_CNT,
   output logic [addr_w-1:0] RA,
   output logic [addr_w-1:0] RB,
   output logic              WE,
   output logic [addr_w-1:0] RW,
   output logic [data_w-1:0] DW,
   input  logic [data_w-1:0] DA,
   input  logic [data_w-1:0] DB
);

   typedef enum logic [2:0] {IDLE, W0, R0W1, DRAIN0, R1, DRAIN1, DONE_ST} state_t;

   localparam logic [addr_w-1:0] LAST = {addr_w{1'b1}};

   // Alternating-bit background XORed with the address, so aliased decodes differ.
   function automatic logic [data_w-1:0] e0(input logic [addr_w-1:0] a);
      logic [data_w-1:0] p;
      for (int i = 0; i < data_w; i++) p[i] = ~i[0];
      return p ^ data_w'(a);
   endfunction

   state_t              state_q;
   logic [addr_w-1:0]   addr_q;
   logic                busy_q, done_q, pass_q, fail_phase_q;
   logic [addr_w-1:0]   fail_addr_q;
   logic [1:0]          fail_port_q;
   logic [7:0]          err_cnt_q;

   logic                pv_q, pphase_q;
   logic [data_w-1:0]   pexp_q;
   logic [addr_w-1:0]   paddr_q;

   logic                cur_v, cur_phase, cmp_v, cmp_phase;
   logic [data_w-1:0]   cur_exp, cmp_exp;
   logic [addr_w-1:0]   cmp_addr;
   logic [1:0]          mism;
   logic [8:0]          err_sum;
   logic [7:0]          err_d;

   // Port drives follow directly from the state and address registers.
   always_comb begin
      WE = 1'b0;
      RA = '0;
      RB = '0;
      RW = '0;
      DW = '0;
      case (state_q)
         W0: begin
            WE = 1'b1;
            RW = addr_q;
            DW = e0(addr_q);
         end
         R0W1: begin
            WE = 1'b1;
            RA = addr_q;
            RB = addr_q;
            RW = addr_q;
            DW = ~e0(addr_q);
         end
         R1: begin
            RA = addr_q;
            RB = addr_q;
         end
         default: ;
      endcase
   end

   // A registered read file returns data a cycle late, so the compare uses the delayed stage.
   always_comb begin
      cur_v     = (state_q == R0W1) || (state_q == R1);
      cur_phase = (state_q == R1);
      cur_exp   = cur_phase ? ~e0(addr_q) : e0(addr_q);
      cmp_v     = (USE_LATCH != 0) ? pv_q     : cur_v;
      cmp_phase = (USE_LATCH != 0) ? pphase_q : cur_phase;
      cmp_exp   = (USE_LATCH != 0) ? pexp_q   : cur_exp;
      cmp_addr  = (USE_LATCH != 0) ? paddr_q  : addr_q;
      mism      = {DB != cmp_exp, DA != cmp_exp} & {2{cmp_v}};
      err_sum   = {1'b0, err_cnt_q} + 9'(mism[0]) + 9'(mism[1]);
      err_d     = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_addr_q  <= '0;
         fail_port_q  <= '0;
         fail_phase_q <= 1'b0;
         err_cnt_q    <= '0;
         pv_q         <= 1'b0;
         pphase_q     <= 1'b0;
         pexp_q       <= '0;
         paddr_q      <= '0;
      end else begin
         pv_q     <= cur_v;
         pphase_q <= cur_phase;
         pexp_q   <= cur_exp;
         paddr_q  <= addr_q;
         if (cmp_v) begin
            err_cnt_q <= err_d;
            if (mism != 2'b00 && err_cnt_q == 8'd0) begin
               fail_addr_q  <= cmp_addr;
               fail_port_q  <= mism;
               fail_phase_q <= cmp_phase;
            end
         end
         case (state_q)
            IDLE, DONE_ST: begin
               if (START) begin
                  state_q      <= W0;
                  addr_q       <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  fail_addr_q  <= '0;
                  fail_port_q  <= '0;
                  fail_phase_q <= 1'b0;
                  err_cnt_q    <= '0;
               end
            end
            W0: begin
               addr_q <= addr_q + 1'b1;
               if (addr_q == LAST) state_q <= R0W1;
            end
            R0W1: begin
               if (addr_q == LAST) state_q <= (USE_LATCH != 0) ? DRAIN0 : R1;
               else                addr_q  <= addr_q + 1'b1;
            end
            DRAIN0: state_q <= R1;
            R1: begin
               if (addr_q == '0) begin
                  if (USE_LATCH != 0) begin
                     state_q <= DRAIN1;
                  end else begin
                     state_q <= DONE_ST;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == 8'd0);
                  end
               end else begin
                  addr_q <= addr_q - 1'b1;
               end
            end
            DRAIN1: begin
               state_q <= DONE_ST;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= (err_d == 8'd0);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign PASS       = pass_q;
   assign FAIL_ADDR  = fail_addr_q;
   assign FAIL_PORT  = fail_port_q;
   assign FAIL_PHASE = fail_phase_q;
   assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_dffrf_bist.sv
// Bench for dffrf_bist: behavioural register files with injectable faults feed
// the controller, and a march-level model predicts the reported results.
module tb_dffrf_bist;

   logic clk, rstN, startAB, start2, fillReq;

   // Same-cycle read instance (dut0) and registered-read instance (dut1), 32 words.
   logic        busy0, done0, pass0, fph0, we0;
   logic [4:0]  faddr0, ra0, rb0, rw0;
   logic [1:0]  fport0;
   logic [7:0]  err0;
   logic [31:0] dw0, da0, db0;

   logic        busy1, done1, pass1, fph1, we1;
   logic [4:0]  faddr1, ra1, rb1, rw1;
   logic [1:0]  fport1;
   logic [7:0]  err1;
   logic [31:0] dw1, da1, db1;

   // 256-word instance whose read ports are stuck at zero.
   logic        busy2, done2, pass2, fph2, we2;
   logic [7:0]  faddr2, ra2, rb2, rw2;
   logic [1:0]  fport2;
   logic [7:0]  err2;
   logic [31:0] dw2;
   logic [31:0] zero32;

   logic [31:0] mem0 [32];
   logic [31:0] mem1 [32];
   logic [31:0] initVals [32];

   int faultType, faultAddr, faultBit;
   int passCnt, totalCnt;
   int expErr, expAddr, expPort, expPhase;

   dffrf_bist #(.data_w(32), .addr_w(5), .USE_LATCH(0)) dut0 (
      .CLK(clk), .RST_N(rstN), .START(startAB), .BUSY(busy0), .DONE(done0), .PASS(pass0),
      .FAIL_ADDR(faddr0), .FAIL_PORT(fport0), .FAIL_PHASE(fph0), .ERR_CNT(err0),
      .RA(ra0), .RB(rb0), .WE(we0), .RW(rw0), .DW(dw0), .DA(da0), .DB(db0));

   dffrf_bist #(.data_w(32), .addr_w(5), .USE_LATCH(1)) dut1 (
      .CLK(clk), .RST_N(rstN), .START(startAB), .BUSY(busy1), .DONE(done1), .PASS(pass1),
      .FAIL_ADDR(faddr1), .FAIL_PORT(fport1), .FAIL_PHASE(fph1), .ERR_CNT(err1),
      .RA(ra1), .RB(rb1), .WE(we1), .RW(rw1), .DW(dw1), .DA(da1), .DB(db1));

   dffrf_bist #(.data_w(32), .addr_w(8), .USE_LATCH(0)) dut2 (
      .CLK(clk), .RST_N(rstN), .START(start2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
      .FAIL_ADDR(faddr2), .FAIL_PORT(fport2), .FAIL_PHASE(fph2), .ERR_CNT(err2),
      .RA(ra2), .RB(rb2), .WE(we2), .RW(rw2), .DW(dw2), .DA(zero32), .DB(zero32));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign zero32 = 32'h0;

   function automatic logic [31:0] pat(input int a);
      return 32'h5555_5555 ^ 32'(a);
   endfunction

   function automatic int aliasOf(input int a, input int ft, input int fa);
      return (ft == 3 && a == fa + 1) ? fa : a;
   endfunction

   function automatic logic [31:0] rdA(input int a, input logic [31:0] v, input int ft, input int fa, input int fb);
      logic [31:0] r;
      r = v;
      if (ft == 1 && a == fa) r[fb] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] rdB(input int a, input logic [31:0] v, input int ft, input int fa, input int fb);
      logic [31:0] r;
      r = v;
      if (ft == 2 && a == fa) r[fb] = 1'b0;
      return r;
   endfunction

   // Faulty register files: dut0 sees combinational reads, dut1 registered reads.
   always_comb begin
      da0 = rdA(int'(ra0), mem0[ra0], faultType, faultAddr, faultBit);
      db0 = rdB(int'(rb0), mem0[rb0], faultType, faultAddr, faultBit);
   end

   always @(posedge clk) begin
      if (fillReq) begin
         for (int i = 0; i < 32; i++) begin
            mem0[i] <= initVals[i];
            mem1[i] <= initVals[i];
         end
      end else begin
         if (we0) mem0[aliasOf(int'(rw0), faultType, faultAddr)] <= dw0;
         if (we1) mem1[aliasOf(int'(rw1), faultType, faultAddr)] <= dw1;
      end
      da1 <= rdA(int'(ra1), mem1[ra1], faultType, faultAddr, faultBit);
      db1 <= rdB(int'(rb1), mem1[rb1], faultType, faultAddr, faultBit);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      if (obs === exp) passCnt++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic scoreRead(input int a, input logic [31:0] e, input int phase, input logic [31:0] stored);
      logic [1:0] mm;
      mm[0] = rdA(a, stored, faultType, faultAddr, faultBit) != e;
      mm[1] = rdB(a, stored, faultType, faultAddr, faultBit) != e;
      if (mm != 2'b00 && expErr == 0) begin
         expAddr  = a;
         expPort  = int'(mm);
         expPhase = phase;
      end
      expErr = expErr + int'(mm[0]) + int'(mm[1]);
      if (expErr > 255) expErr = 255;
   endtask

   // The march played out on an array: write all, read-then-invert ascending, read descending.
   task automatic modelRun();
      logic [31:0] m [32];
      expErr = 0; expAddr = 0; expPort = 0; expPhase = 0;
      for (int i = 0; i < 32; i++) m[i] = initVals[i];
      for (int a = 0; a < 32; a++) m[aliasOf(a, faultType, faultAddr)] = pat(a);
      for (int a = 0; a < 32; a++) begin
         scoreRead(a, pat(a), 0, m[a]);
         m[aliasOf(a, faultType, faultAddr)] = ~pat(a);
      end
      for (int a = 31; a >= 0; a--) scoreRead(a, ~pat(a), 1, m[a]);
   endtask

   task automatic applyStimulus(input string tag);
      int b0, b1;
      b0 = 0; b1 = 0;
      for (int i = 0; i < 32; i++) initVals[i] = $urandom;
      modelRun();
      @(negedge clk); fillReq = 1'b1;
      @(negedge clk); fillReq = 1'b0; startAB = 1'b1;
      @(negedge clk); startAB = 1'b0;
      for (int cyc = 0; cyc < 400 && (busy0 || busy1); cyc++) begin
         if (busy0) b0++;
         if (busy1) begin
            if (b1 == 64 || b1 == 97) checkOutput($sformatf("%s drainWe@%0d", tag, b1), 32'(we1), 32'd0);
            b1++;
         end
         startAB = busy0 && busy1 && ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      startAB = 1'b0;
      checkOutput({tag, " busyCycles0"}, 32'(b0), 32'd96);
      checkOutput({tag, " busyCycles1"}, 32'(b1), 32'd98);
      checkOutput({tag, " done0"}, 32'(done0), 32'd1);
      checkOutput({tag, " done1"}, 32'(done1), 32'd1);
      checkOutput({tag, " pass0"}, 32'(pass0), 32'(expErr == 0));
      checkOutput({tag, " pass1"}, 32'(pass1), 32'(expErr == 0));
      checkOutput({tag, " errCnt0"}, 32'(err0), 32'(expErr));
      checkOutput({tag, " errCnt1"}, 32'(err1), 32'(expErr));
      if (expErr != 0) begin
         checkOutput({tag, " failAddr0"}, 32'(faddr0), 32'(expAddr));
         checkOutput({tag, " failAddr1"}, 32'(faddr1), 32'(expAddr));
         checkOutput({tag, " failPort0"}, 32'(fport0), 32'(expPort));
         checkOutput({tag, " failPort1"}, 32'(fport1), 32'(expPort));
         checkOutput({tag, " failPhase0"}, 32'(fph0), 32'(expPhase));
         checkOutput({tag, " failPhase1"}, 32'(fph1), 32'(expPhase));
      end
   endtask

   initial begin
      passCnt = 0; totalCnt = 0;
      rstN = 1'b0; startAB = 1'b0; start2 = 1'b0; fillReq = 1'b0;
      faultType = 0; faultAddr = 0; faultBit = 0;
      for (int i = 0; i < 32; i++) initVals[i] = $urandom;
      repeat (3) @(negedge clk);
      checkOutput("rst busy", 32'(busy0), 32'd0);
      checkOutput("rst done", 32'(done0), 32'd0);
      checkOutput("rst we", 32'(we1), 32'd0);
      checkOutput("rst errCnt", 32'(err0), 32'd0);
      checkOutput("rst dw", dw0, 32'd0);
      rstN = 1'b1;
      @(negedge clk);

      applyStimulus("clean");
      if (expErr != 0) $display("[TB] note: clean run model reported errors");
      checkOutput("clean modelPass", 32'(pass0), 32'd1);

      faultType = 1; faultAddr = 5; faultBit = 3;
      applyStimulus("portA");
      checkOutput("portA addr", 32'(faddr0), 32'd5);
      checkOutput("portA port", 32'(fport1), 32'd1);
      checkOutput("portA err", 32'(err0), 32'd1);

      faultType = 3; faultAddr = 8;
      applyStimulus("alias");
      checkOutput("alias addr", 32'(faddr1), 32'd8);
      checkOutput("alias port", 32'(fport0), 32'd3);
      checkOutput("alias phase", 32'(fph0), 32'd0);

      for (int r = 0; r < 6; r++) begin
         faultType = $urandom_range(0, 3);
         faultAddr = $urandom_range(0, 30);
         faultBit  = $urandom_range(0, 31);
         applyStimulus($sformatf("rand%0d", r));
      end

      // Saturation on the wide instance.
      begin
         int b2;
         b2 = 0;
         @(negedge clk); start2 = 1'b1;
         @(negedge clk); start2 = 1'b0;
         for (int cyc = 0; cyc < 1000 && busy2; cyc++) begin
            b2++;
            @(negedge clk);
         end
         checkOutput("sat busyCycles", 32'(b2), 32'd768);
         checkOutput("sat errCnt", 32'(err2), 32'd255);
         checkOutput("sat done", 32'(done2), 32'd1);
         checkOutput("sat pass", 32'(pass2), 32'd0);
         checkOutput("sat failAddr", 32'(faddr2), 32'd0);
         checkOutput("sat failPort", 32'(fport2), 32'd3);
      end

      // Asynchronous abort mid-run, then a clean run after release.
      faultType = 3; faultAddr = 2;
      @(negedge clk); fillReq = 1'b1;
      @(negedge clk); fillReq = 1'b0; startAB = 1'b1;
      @(negedge clk); startAB = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("preAbort errCnt", 32'(err0 != 0), 32'd1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("abort we0", 32'(we0), 32'd0);
      checkOutput("abort we1", 32'(we1), 32'd0);
      checkOutput("abort busy0", 32'(busy0), 32'd0);
      checkOutput("abort busy1", 32'(busy1), 32'd0);
      checkOutput("abort errCnt", 32'(err0), 32'd0);
      @(negedge clk); rstN = 1'b1;
      repeat (2) @(negedge clk);
      faultType = 0;
      applyStimulus("afterAbort");
      checkOutput("afterAbort pass", 32'(pass1), 32'd1);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/dffrf_bist.md
Name: dffrf_bist

Overview:
- March-style built-in self-test controller for the 2R1W flop register file.
- Sits directly in front of the file: drives its write port (RW/WE/DW) and both read addresses (RA/RB), and consumes both read data ports (DA/DB).
- Writes address-keyed patterns, reads every word back through both ports, and reports pass/fail, the first failing location and a saturating error count.
- Muxed onto the file's ports by the integrator during test mode.

Parameters:
- data_w, 32, register file data width.
- addr_w, 5, register file address width; depth N = 2**addr_w.
- USE_LATCH, 0, must match the file's setting. 0: read data valid in the same cycle as the address. 1: read data valid one cycle after the address.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  run request; sampled only in IDLE.
- BUSY  out  1  test in progress.
- DONE  out  1  sticky completion flag.
- PASS  out  1  valid when DONE=1; 1 = no mismatches.
- FAIL_ADDR  out  addr_w  address of the first mismatch.
- FAIL_PORT  out  2  ports mismatching at the first failure: bit0 = A, bit1 = B.
- FAIL_PHASE  out  1  phase of the first failure: 0 = R0W1, 1 = R1.
- ERR_CNT  out  8  saturating mismatch count.
- RA  out  addr_w  read address, port A.
- RB  out  addr_w  read address, port B.
- WE  out  1  write enable.
- RW  out  addr_w  write address.
- DW  out  data_w  write data.
- DA  in  data_w  read data, port A.
- DB  in  data_w  read data, port B.

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; all outputs 0 (WE=0, RA=RB=RW=0, DW=0, BUSY=DONE=PASS=0, FAIL_*=0, ERR_CNT=0).
- Reset mid-run aborts immediately; WE is deasserted without waiting for a clock. There is no partial-result retention.
- Pattern definitions:
  - P = alternating bits, bit i = ~i[0] (0x55555555 for 32 bits).
  - E0(a) = P ^ zero-extended a.
  - E1(a) = ~E0(a).
  - Keying on the address exposes decoder aliasing.
- States: IDLE -> W0 -> R0W1 -> R1 -> DONE_ST.
- IDLE: START=1 at a posedge clears DONE, PASS, FAIL_*, ERR_CNT, sets BUSY, enters W0 with address counter = 0. START while BUSY=1 is ignored.
- W0 (N cycles, ascending a = 0..N-1): WE=1, RW=a, DW=E0(a).
- R0W1 (N cycles, ascending): RA=RB=RW=a, WE=1, DW=E1(a). Reading and writing the same address in one cycle returns the old value E0(a), because the write lands at the edge. Both DA and DB are compared against E0(a).
- R1 (N cycles, descending a = N-1..0): WE=0, RA=RB=a; both ports are compared against E1(a).
- Compare timing:
  - USE_LATCH=0: compare in the same cycle as the address.
  - USE_LATCH=1: expected value, address and phase are registered one stage; compare one cycle later.
  - Each read phase then adds one drain cycle with WE=0 before the next state.
  - The R0W1 drain cycle precedes R1's first read, so the last write settles before R1.
- Error accounting per compare cycle:
  - m = {DB!=exp, DA!=exp}; ERR_CNT += popcount(m), saturating at 255.
  - On the first cycle with m!=0 (ERR_CNT was 0), capture FAIL_ADDR, FAIL_PORT=m and FAIL_PHASE. These are held for the rest of the run.
- DONE_ST: entered on the edge after the last compare. BUSY=0, DONE=1, PASS=(ERR_CNT==0), WE=0, addresses 0. Remains in DONE_ST until START=1, which restarts exactly as from IDLE.
- BUSY duration: exactly 3N cycles (USE_LATCH=0) or 3N+2 cycles (USE_LATCH=1).
- Address counter wraps only at phase boundaries; no counter overflow into the next phase.

Test Plan:
- Clean run, addr_w=5, USE_LATCH=0, fault-free file: pulse START -> BUSY high 96 cycles; DONE=1, PASS=1, ERR_CNT=0.
- Clean run, USE_LATCH=1 -> BUSY high 98 cycles; PASS=1. Check WE=0 during both drain cycles.
- Fault on port A only: DA bit3 forced 1 whenever RA==5 (E0(5)=0x55555550 has bit3=0) -> first failure FAIL_ADDR=5, FAIL_PORT=2'b01, FAIL_PHASE=0. ERR_CNT=1 (E1(5) bit3 is already 1); PASS=0.
- Decoder alias, write address 9 aliased onto 8: bench remaps RW -> FAIL_ADDR=8, FAIL_PORT=2'b11, FAIL_PHASE=0; PASS=0.
- DA and DB forced to 0, addr_w=8 -> ERR_CNT saturates at 255 (1024 mismatches), DONE after 768 cycles.
- RST_N low at cycle 40 of a run -> WE, BUSY, ERR_CNT read 0 asynchronously. START 3 cycles after release -> full clean run completes with PASS=1. START pulsed mid-run -> no effect on the cycle count.
